// File: rtl/perceptron_core_pkg.sv
// Shared NPU definitions: element width, default fan-in, accumulator sizing
// and the saturating ReLU used by the perceptron output stage.
package kiwi_npu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int N_DEFAULT  = 4;
  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int SAT_W      = 64;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic signed [PROD_W-1:0]     prod_t;
  typedef logic signed [SAT_W-1:0]      wide_t;

  localparam wide_t Y_MAX = (wide_t'(1) <<< (DATA_WIDTH - 1)) - wide_t'(1);

  // Width that holds N full-precision products plus the bias without overflow.
  function automatic int acc_w(input int n, input int dw);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  // Clamp negatives to zero and large positives to the data_t maximum.
  function automatic data_t relu_sat(input wide_t acc);
    data_t r;
    if (acc <= wide_t'(0)) begin
      r = '0;
    end else if (acc > Y_MAX) begin
      r = data_t'(Y_MAX[DATA_WIDTH-1:0]);
    end else begin
      r = data_t'(acc[DATA_WIDTH-1:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/perceptron_core_if.sv
// Data bundle of one perceptron: packed input/weight vectors, bias and result.
interface perceptron_core_if
  import kiwi_npu_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic [N*DATA_WIDTH-1:0] x;
  logic [N*DATA_WIDTH-1:0] w;
  data_t                   b;
  data_t                   y;

  modport master (output x, output w, output b, input y);
  modport slave  (input x, input w, input b, output y);

endinterface

// File: rtl/perceptron_core_mult.sv
// One signed DATA_WIDTH x DATA_WIDTH multiplier with a full-precision product.
module perceptron_mult
  import kiwi_npu_pkg::*;
(
  input  data_t a,
  input  data_t b,
  output prod_t p
);

  // Operands are sign-extended to product width so -2^(W-1) squared is exact.
  assign p = prod_t'(a) * prod_t'(b);

endmodule

// File: rtl/perceptron_core.sv
// Single-neuron inference: y = ReLU_sat(sum x[i]*w[i] + b), two-stage pipeline.
module perceptron_core
  import kiwi_npu_pkg::*;
#(
  parameter int N = N_DEFAULT
)(
  input  logic                clk,
  input  logic                rst,
  perceptron_core_if.slave    bus
);

  localparam int ACC_W = acc_w(N, DATA_WIDTH);

  prod_t              p_d [N];
  prod_t              p_q [N];
  data_t              b_q;
  logic signed [ACC_W-1:0] acc;
  data_t              y_q;

  for (genvar g = 0; g < N; g++) begin : g_mult
    perceptron_mult u_mult (
      .a (data_t'(bus.x[g*DATA_WIDTH +: DATA_WIDTH])),
      .b (data_t'(bus.w[g*DATA_WIDTH +: DATA_WIDTH])),
      .p (p_d[g])
    );
  end

  // Stage 1: capture the products and the bias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        p_q[i] <= '0;
      end
      b_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        p_q[i] <= p_d[i];
      end
      b_q <= bus.b;
    end
  end

  // Stage 2 adder tree: bias plus all sign-extended products.
  always_comb begin
    acc = ACC_W'(b_q);
    for (int unsigned i = 0; i < N; i++) begin
      acc = acc + ACC_W'(p_q[i]);
    end
  end

  // Stage 2: register the saturated ReLU of the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= relu_sat(SAT_W'(acc));
    end
  end

  assign bus.y = y_q;

endmodule

// File: tb/tb_perceptron_core.sv
// Scoreboard bench for perceptron_core: stimulus pushes reference results,
// an independent monitor pops and compares two edges after each vector.
module tb_perceptron_core;
  import kiwi_npu_pkg::*;

  localparam int NV = 4;
  localparam int YMAX_I = (1 << (DATA_WIDTH - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  perceptron_core_if #(.N(NV)) bus ();

  perceptron_core #(.N(NV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int q[$];
  int total = 0;
  int bad   = 0;
  bit issued = 1'b0;
  bit v1 = 1'b0;
  bit v2 = 1'b0;

  // Reference: plain integer dot product, bias, then clamp to [0, YMAX].
  function automatic int model(input logic [NV*DATA_WIDTH-1:0] xv,
                               input logic [NV*DATA_WIDTH-1:0] wv,
                               input logic [DATA_WIDTH-1:0] bv);
    int acc;
    acc = int'($signed(bv));
    for (int i = 0; i < NV; i++) begin
      acc += int'($signed(xv[i*DATA_WIDTH +: DATA_WIDTH])) *
             int'($signed(wv[i*DATA_WIDTH +: DATA_WIDTH]));
    end
    if (acc <= 0) return 0;
    if (acc > YMAX_I) return YMAX_I;
    return acc;
  endfunction

  function automatic logic [4*DATA_WIDTH-1:0] pack4(input int a0, input int a1,
                                                    input int a2, input int a3);
    return {DATA_WIDTH'(a3), DATA_WIDTH'(a2), DATA_WIDTH'(a1), DATA_WIDTH'(a0)};
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input int a0, input int a1, input int a2, input int a3,
                       input int w0, input int w1, input int w2, input int w3,
                       input int bias);
    @(negedge clk);
    bus.x = pack4(a0, a1, a2, a3);
    bus.w = pack4(w0, w1, w2, w3);
    bus.b = DATA_WIDTH'(bias);
    q.push_back(model(bus.x, bus.w, bus.b));
    issued = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.x = '0;
    bus.w = '0;
    bus.b = '0;
    issued = 1'b0;
  endtask

  function automatic int pick();
    case ($urandom_range(0, 4))
      0:       return -128;
      1:       return 127;
      2:       return 0;
      default: return int'($signed(8'($urandom)));
    endcase
  endfunction

  // Monitor: a result is due two edges after an issued vector; otherwise y must be 0.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        v1 = 1'b0;
        v2 = 1'b0;
      end else begin
        v2 = v1;
        v1 = issued;
      end
      issued = 1'b0;
      #1;
      if (v2) begin
        if (q.size() == 0) check("underflow", bus.y, -999);
        else               check("y", $signed(bus.y), q.pop_front());
      end else begin
        check("idle_zero", $signed(bus.y), 0);
      end
    end
  end

  initial begin
    bus.x = '0;
    bus.w = '0;
    bus.b = '0;
    #2;
    check("reset_y", $signed(bus.y), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases with gaps between them.
    apply(1, 2, 3, 4,  1, 1, 1, 1,  0);   idle();
    apply(1, 2, 3, 4,  1, 1, 1, 1, -3);   idle();
    apply(-1, -2, -3, -4, 1, 1, 1, 1, 0); idle();
    apply(0, 0, 0, 0,  0, 0, 0, 0, -5);   idle();
    apply(0, 0, 0, 0,  0, 0, 0, 0,  5);   idle();
    apply(127, 127, 127, 127, 127, 127, 127, 127, 127); idle();
    apply(-128, -128, -128, -128, -128, -128, -128, -128, -128); idle();
    apply(127, 0, 0, 0, 1, 0, 0, 0, 0);   idle();
    apply(127, 0, 0, 0, 1, 0, 0, 0, 1);   idle();
    apply(-128, 0, 0, 0, -128, 0, 0, 0, -128); idle(); idle();

    // Back-to-back streaming of five vectors.
    apply(5, 6, 7, 8,   1, 2, 3, 4,  -10);
    apply(2, 2, 2, 2,   3, 3, 3, 3,    1);
    apply(-7, 9, 3, 1,  4, 2, -1, 5,   0);
    apply(10, -10, 1, 1, 10, 10, 1, 1, 99);
    apply(1, 1, 1, 1,   1, 1, 1, 1, -128);
    idle(); idle();

    // Randomized stream with occasional bubbles.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else apply(pick(), pick(), pick(), pick(),
                 pick(), pick(), pick(), pick(), pick());
    end

    // Reset mid-stream: in-flight results discarded, y clears without an edge.
    apply(10, 10, 10, 10, 1, 1, 1, 1, 0);
    apply(20, 10, 10, 10, 1, 1, 1, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.x = '0;
    bus.w = '0;
    bus.b = '0;
    issued = 1'b0;
    q.delete();
    #1;
    check("async_clr", $signed(bus.y), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.x = pack4(3, 3, 3, 3);
    bus.w = pack4(2, 2, 2, 2);
    bus.b = DATA_WIDTH'(1);
    q.push_back(model(bus.x, bus.w, bus.b));
    issued = 1'b1;
    idle(); idle();
    apply(50, 50, 0, 0, 1, 1, 0, 0, 0);
    repeat (4) idle();

    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the run in case the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
